// File: rtl/transform_twiddle.sv
// Twiddle multiplier between radix-2 butterfly stages: sum samples pass, diff samples are
// rotated by W_N^k with rounding and saturation, through a 3-stage pipeline with backpressure.
module transform_twiddle #(
  parameter int WIDTH    = 16,
  parameter int N        = 64,
  parameter int TW_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [2*WIDTH+1:0]   s_data,
  input  logic                 s_last,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [2*WIDTH+1:0]   m_data,
  output logic                 m_last
);

  localparam int  DW     = WIDTH + 1;
  localparam int  PW     = DW + TW_WIDTH;
  localparam int  SW     = PW + 1;
  localparam int  LOG2N  = $clog2(N);
  localparam int  TW_MAX = 2 ** (TW_WIDTH - 1) - 1;
  localparam int  TW_MIN = -(2 ** (TW_WIDTH - 1));
  localparam real PI     = 3.14159265358979323846;

  localparam logic signed [SW-1:0] RND     = SW'(1) << (TW_WIDTH - 2);
  localparam logic signed [SW-1:0] SAT_MAX = {{(SW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = {{(SW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  function automatic logic signed [TW_WIDTH-1:0] tw_coef(input real x);
    real    s;
    integer r;
    s = x * (2.0 ** (TW_WIDTH - 1));
    if (s >= 0.0) r = $rtoi(s + 0.5);
    else          r = -$rtoi(0.5 - s);
    if (r > TW_MAX) r = TW_MAX;
    if (r < TW_MIN) r = TW_MIN;
    return r[TW_WIDTH-1:0];
  endfunction

  function automatic logic signed [DW-1:0] sat(input logic signed [SW-1:0] x);
    if (x > SAT_MAX)      return SAT_MAX[DW-1:0];
    else if (x < SAT_MIN) return SAT_MIN[DW-1:0];
    else                  return x[DW-1:0];
  endfunction

  // Coefficient table is fixed at elaboration; only the lookup is hardware.
  logic signed [TW_WIDTH-1:0] w_rom_c [N/2];
  logic signed [TW_WIDTH-1:0] w_rom_d [N/2];

  for (genvar k = 0; k < N/2; k++) begin : g_rom
    localparam real ANG = 2.0 * PI * k / N;
    localparam logic signed [TW_WIDTH-1:0] C = tw_coef($cos(ANG));
    localparam logic signed [TW_WIDTH-1:0] D = tw_coef(-$sin(ANG));
    assign w_rom_c[k] = C;
    assign w_rom_d[k] = D;
  end

  logic                       w_en;
  logic                       w_accept;
  logic [LOG2N-2:0]           w_k;
  logic [LOG2N-1:0]           r_cnt;

  logic                       r1_valid, r1_last, r1_diff;
  logic signed [DW-1:0]       r1_re, r1_im;
  logic signed [TW_WIDTH-1:0] r1_c, r1_d;

  logic                       r2_valid, r2_last, r2_diff;
  logic signed [DW-1:0]       r2_re, r2_im;
  logic signed [PW-1:0]       r2_ac, r2_bd, r2_ad, r2_bc;

  logic                       r_m_valid, r_m_last;
  logic signed [DW-1:0]       r_m_re, r_m_im;

  logic signed [SW-1:0]       w_sum_re, w_sum_im;
  logic signed [SW-1:0]       w_shr_re, w_shr_im;

  assign w_en     = !r_m_valid || m_ready;
  assign w_accept = s_valid && w_en;
  assign w_k      = r_cnt[LOG2N-1:1];

  assign s_ready  = w_en;
  assign m_valid  = r_m_valid;
  assign m_last   = r_m_last;
  assign m_data   = {r_m_im, r_m_re};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= '0;
      r1_valid  <= 1'b0;
      r1_last   <= 1'b0;
      r2_valid  <= 1'b0;
      r2_last   <= 1'b0;
      r_m_valid <= 1'b0;
      r_m_last  <= 1'b0;
    end else if (w_en) begin
      if (w_accept) r_cnt <= s_last ? '0 : r_cnt + 1'b1;
      r1_valid  <= w_accept;
      r1_last   <= w_accept && s_last;
      r2_valid  <= r1_valid;
      r2_last   <= r1_valid && r1_last;
      r_m_valid <= r2_valid;
      r_m_last  <= r2_valid && r2_last;
    end
  end

  // Full-precision complex product, then round half up and saturate.
  assign w_sum_re = r2_ac - r2_bd;
  assign w_sum_im = r2_ad + r2_bc;
  assign w_shr_re = (w_sum_re + RND) >>> (TW_WIDTH - 1);
  assign w_shr_im = (w_sum_im + RND) >>> (TW_WIDTH - 1);

  always_ff @(posedge clk) begin
    if (w_en) begin
      r1_re   <= s_data[DW-1:0];
      r1_im   <= s_data[2*DW-1:DW];
      r1_diff <= r_cnt[0];
      r1_c    <= w_rom_c[w_k];
      r1_d    <= w_rom_d[w_k];

      r2_re   <= r1_re;
      r2_im   <= r1_im;
      r2_diff <= r1_diff;
      r2_ac   <= r1_re * r1_c;
      r2_bd   <= r1_im * r1_d;
      r2_ad   <= r1_re * r1_d;
      r2_bc   <= r1_im * r1_c;

      r_m_re  <= r2_diff ? sat(w_shr_re) : r2_re;
      r_m_im  <= r2_diff ? sat(w_shr_im) : r2_im;
    end
  end

endmodule

// File: tb/tb_transform_twiddle.sv
// Bench for transform_twiddle: directed pair/saturation/reset cases plus random streams with
// random backpressure, checked against a trigonometric reference model.
module tb_transform_twiddle;

  localparam int  WIDTH    = 16;
  localparam int  N        = 64;
  localparam int  TW_WIDTH = 16;
  localparam int  DW       = WIDTH + 1;
  localparam int  BW       = 2 * WIDTH + 2;
  localparam real PI       = 3.14159265358979323846;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_last = 1'b0;
  logic          m_ready = 1'b1;
  logic [BW-1:0] s_data = '0;
  logic          s_ready, m_valid, m_last;
  logic [BW-1:0] m_data;

  int checks = 0;
  int errors = 0;

  logic [BW-1:0] exp_q[$];
  logic          exp_l[$];
  int            mcnt = 0;
  bit            prev_stall = 0;
  logic [BW-1:0] prev_data;
  logic          prev_last;

  transform_twiddle #(.WIDTH(WIDTH), .N(N), .TW_WIDTH(TW_WIDTH)) dut (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic longint round_clamp(input real x, input longint lo, input longint hi);
    longint r;
    if (x >= 0.0) r = longint'($floor(x + 0.5));
    else          r = -longint'($floor(-x + 0.5));
    if (r > hi) r = hi;
    if (r < lo) r = lo;
    return r;
  endfunction

  // Twiddle W_N^k scaled to Q1.(TW_WIDTH-1); rounded product scaled back by 2^(TW_WIDTH-1).
  function automatic logic [BW-1:0] ref_out(input logic [BW-1:0] d, input int idx);
    longint a, b, c, s, re, im, tmax, dmax;
    real    ang;
    if (idx % 2 == 0) return d;
    tmax = 64'sd1 <<< (TW_WIDTH - 1);
    dmax = 64'sd1 <<< (DW - 1);
    a   = longint'($signed(d[DW-1:0]));
    b   = longint'($signed(d[BW-1:DW]));
    ang = 2.0 * PI * real'(idx / 2) / real'(N);
    c   = round_clamp($cos(ang) * real'(tmax), -tmax, tmax - 1);
    s   = round_clamp(-$sin(ang) * real'(tmax), -tmax, tmax - 1);
    re  = a * c - b * s;
    im  = a * s + b * c;
    re  = longint'($floor(real'(re) / real'(tmax) + 0.5));
    im  = longint'($floor(real'(im) / real'(tmax) + 0.5));
    if (re > dmax - 1) re = dmax - 1;
    if (re < -dmax)    re = -dmax;
    if (im > dmax - 1) im = dmax - 1;
    if (im < -dmax)    im = -dmax;
    return {im[DW-1:0], re[DW-1:0]};
  endfunction

  function automatic logic [BW-1:0] pack(input int re, input int im);
    logic [31:0] r, i;
    r = re;
    i = im;
    return {i[DW-1:0], r[DW-1:0]};
  endfunction

  function automatic logic [BW-1:0] rnd_data();
    logic [31:0] x, y;
    x = $urandom;
    y = $urandom;
    return {x[DW-1:0], y[DW-1:0]};
  endfunction

  // Scoreboard: everything is sampled at the falling edge, half a cycle from the active edge.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      exp_l.delete();
      mcnt       = 0;
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        check("hold_data", m_data, prev_data);
        check("hold_last", m_last, prev_last);
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL unexpected_output: observed %h expected none", m_data);
        end else begin
          check("out_data", m_data, exp_q.pop_front());
          check("out_last", m_last, exp_l.pop_front());
        end
      end
      if (s_valid && s_ready) begin
        exp_q.push_back(ref_out(s_data, mcnt));
        exp_l.push_back(s_last);
        mcnt = s_last ? 0 : (mcnt + 1) % N;
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input logic [BW-1:0] d, input logic last, input bit rnd_rdy);
    bit acc;
    int n;
    n       = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    do begin
      if (rnd_rdy) m_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      acc = s_ready;
      sync();
      n++;
    end while (!acc && n < 200);
    if (!acc) begin
      checks++;
      errors++;
      $error("FAIL send_timeout: accepted %0d required 1", acc);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic reset_dut(input int n);
    reset   = 1'b1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("reset_m_valid", m_valid, 1'b0);
    check("reset_m_last", m_last, 1'b0);
    repeat (n - 1) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", s_ready, 1'b1);
    sync();
  endtask

  task automatic expect_out(input string tag, input logic [BW-1:0] exp);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_valid"}, m_valid, 1'b1);
    check({tag, "_data"}, m_data, exp);
  endtask

  initial begin
    reset_dut(3);

    // k=0 pair, with exact latency.
    send(pack(100, -50), 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("k0_sum_early", m_valid, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("k0_sum_valid", m_valid, 1'b1);
    check("k0_sum_data", m_data, pack(100, -50));
    sync();
    send(pack(1000, 2000), 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("k0_diff_early", m_valid, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("k0_diff_valid", m_valid, 1'b1);
    check("k0_diff_data", m_data, pack(1000, 2000));
    sync();

    // k=16: multiply by -j.
    reset_dut(2);
    for (int i = 0; i < 32; i++) send(rnd_data(), 1'b0, 1'b0);
    send(pack(1234, -567), 1'b0, 1'b0);
    send(pack(1000, 2000), 1'b0, 1'b0);
    expect_out("k16_diff", pack(2000, -1000));
    sync();

    // k=8 with full-scale negative input saturates the real part.
    reset_dut(2);
    for (int i = 0; i < 16; i++) send(rnd_data(), 1'b0, 1'b0);
    send(pack(-4321, 77), 1'b0, 1'b0);
    send(pack(-65536, -65536), 1'b0, 1'b0);
    expect_out("k8_sat", pack(-65536, 0));
    sync();

    // Fill the pipeline while stalled, then reset: nothing stale may come out.
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(rnd_data(), 1'b0, 1'b0);
    reset_dut(2);
    m_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("no_stale", m_valid, 1'b0);
    end
    sync();

    // Random streams under random backpressure: full frame, natural wrap, short frame.
    for (int i = 0; i < 64; i++) send(rnd_data(), i == 63, 1'b1);
    for (int i = 0; i < 70; i++) send(rnd_data(), 1'b0, 1'b1);
    for (int i = 0; i < 26; i++) send(rnd_data(), i == 9, 1'b1);
    m_ready = 1'b1;
    for (int t = 0; t < 20 && exp_q.size() != 0; t++) @(negedge clk);
    @(negedge clk);
    check("drain_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/transform_twiddle.md
TRANSFORM_TWIDDLE -- requirements
Module: transform_twiddle

Interface
REQ-001 Parameter WIDTH, default 16, upstream butterfly input width; each stream component here is WIDTH+1 bits signed.
REQ-002 Parameter N, default 64, transform length; power of two, 4..1024.
REQ-003 Parameter TW_WIDTH, default 16, twiddle coefficient width, signed Q1.(TW_WIDTH-1).
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 s_valid  input  1  input sample valid.
REQ-007 s_ready  output  1  input sample accepted when s_valid && s_ready.
REQ-008 s_data  input  2*WIDTH+2  {imag[2*WIDTH+1:WIDTH+1], real[WIDTH:0]}, signed, butterfly output order: sum, diff, sum, diff, ...
REQ-009 s_last  input  1  marks final sample of a frame.
REQ-010 m_valid  output  1  output sample valid.
REQ-011 m_ready  input  1  downstream accepts when m_valid && m_ready.
REQ-012 m_data  output  2*WIDTH+2  {imag, real}, same packing and width as s_data.
REQ-013 m_last  output  1  s_last delayed in lockstep with its sample.

Function
REQ-014 Sample counter cnt, log2(N) bits, SHALL increment on each accepted input and wrap N-1 -> 0.
REQ-015 cnt[0]=0 (sum) samples SHALL pass through unmodified; cnt[0]=1 (diff) samples SHALL be multiplied by W_N^k, k = cnt[log2(N)-1:1], range 0..N/2-1.
REQ-016 Twiddle ROM, N/2 entries, SHALL hold c=round(cos(2*pi*k/N)*2^(TW_WIDTH-1)), d=round(-sin(2*pi*k/N)*2^(TW_WIDTH-1)), computed at elaboration, clamped to [-2^(TW_WIDTH-1), 2^(TW_WIDTH-1)-1] (k=0 gives c=32767 at defaults).
REQ-017 Product (a+jb)(c+jd): real = a*c - b*d, imag = a*d + b*c, full precision (WIDTH+TW_WIDTH+2 bits), no intermediate truncation.
REQ-018 Scaling: add 2^(TW_WIDTH-2), arithmetic shift right TW_WIDTH-1 (round half up), then saturate to WIDTH+1 signed range.
REQ-019 Pipeline SHALL be exactly 3 stages (ROM read/register, multiply, add-round-saturate); latency 3 accepted cycles input to m_valid when m_ready held high.
REQ-020 Pass-through samples SHALL traverse the same 3 stages; output order equals input order.
REQ-021 Pipeline enable en = !m_valid || m_ready; s_ready = en; all stages advance only when en=1; bubbles propagate as valid=0.
REQ-022 Throughput SHALL be one sample per cycle with s_valid and m_ready continuously high.
REQ-023 While m_valid=1 and m_ready=0, m_data and m_last SHALL hold stable.
REQ-024 Accepted sample with s_last=1 SHALL force cnt to 0 for the next sample, regardless of current cnt (including mid-frame and odd-length frames).
REQ-025 s_last coinciding with cnt=N-1 SHALL behave identically to natural wrap.

Reset
REQ-026 On reset: cnt=0, all pipeline valid bits 0, m_valid=0, m_last=0; m_data value don't-care.
REQ-027 Reset mid-frame SHALL discard all in-flight samples; first sample accepted after reset is treated as cnt=0 (sum).
REQ-028 s_ready SHALL be 1 in the cycle after reset deasserts.

Verification
REQ-029 Reset: assert reset 2 cycles with pipeline full -> m_valid=0 next cycle, no stale output after release.
REQ-030 Pair k=0: sum (100,-50), diff (1000,2000) -> outputs (100,-50) then (1000,2000), 3 cycles latency each.
REQ-031 k=16, N=64 (W=-j, c=0, d=-32768): diff (1000,2000) -> (2000,-1000) exactly; sum passes unchanged.
REQ-032 Saturation k=8 (c=23170, d=-23170): diff (-65536,-65536) -> real saturates to -65536, imag 0.
REQ-033 Backpressure: 64-sample random stream, m_ready random 50% duty -> all 64 outputs match golden model in order, m_data stable while stalled, m_last on sample 63 only.
REQ-034 s_last on sample 9 of a frame -> sample 10 treated as k=0 sum, m_last aligned with output 9.
